// File: rtl/ei_cmd_parser.sv
// Byte-framed read/write command parser between the UART and the BLE setup register memory.
// Frames: A5 'W' ADDR DATA CHK or A5 'R' ADDR CHK; replies ACK (+data), NAK, or nothing on timeout.
module ei_cmd_parser #(
    parameter int NUM_REGS       = 41,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [5:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       err_pulse,
    output logic [1:0] err_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    NUM_REGS_B = 8'(NUM_REGS);

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam logic [1:0] ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_CMD     = 2'b01;
    localparam logic [1:0] ERR_ADDR    = 2'b10;
    localparam logic [1:0] ERR_CHK     = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK,
        S_EXEC, S_RD_WAIT, S_TX_ACK, S_TX_DATA, S_TX_NAK
    } state_t;

    state_t          state_q, state_d;
    logic            op_wr_q, op_wr_d;
    logic [5:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      acc_q, acc_d;
    logic            bad_addr_q, bad_addr_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            in_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            acc_q      <= '0;
            bad_addr_q <= 1'b0;
            rdata_q    <= '0;
            err_code_q <= ERR_TIMEOUT;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            acc_q      <= acc_d;
            bad_addr_q <= bad_addr_d;
            rdata_q    <= rdata_d;
            err_code_q <= err_code_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        acc_d      = acc_q;
        bad_addr_d = bad_addr_q;
        rdata_d    = rdata_q;
        err_code_d = err_code_q;
        tmo_d      = '0;
        err_pulse  = 1'b0;
        reg_we     = 1'b0;
        reg_re     = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;

        in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                   (state_q == S_DATA) || (state_q == S_CHK);

        // The inter-byte timer only runs while a frame is open; any received byte restarts it.
        if (in_frame && !rx_valid) begin
            if (tmo_q == TMO_LAST) begin
                err_code_d = ERR_TIMEOUT;
                err_pulse  = 1'b1;
                state_d    = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SOF_BYTE) state_d = S_CMD;
            end
            S_CMD: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        op_wr_d = (rx_data == CMD_WR);
                        acc_d   = rx_data;
                        state_d = S_ADDR;
                    end else begin
                        err_code_d = ERR_CMD;
                        err_pulse  = 1'b1;
                        state_d    = S_TX_NAK;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d     = rx_data[5:0];
                    acc_d      = acc_q ^ rx_data;
                    bad_addr_d = (rx_data >= NUM_REGS_B);
                    state_d    = op_wr_q ? S_DATA : S_CHK;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    wdata_d = rx_data;
                    acc_d   = acc_q ^ rx_data;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data != acc_q) begin
                        err_code_d = ERR_CHK;
                        err_pulse  = 1'b1;
                        state_d    = S_TX_NAK;
                    end else if (bad_addr_q) begin
                        err_code_d = ERR_ADDR;
                        err_pulse  = 1'b1;
                        state_d    = S_TX_NAK;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (op_wr_q) begin
                    reg_we  = 1'b1;
                    state_d = S_TX_ACK;
                end else begin
                    reg_re  = 1'b1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                rdata_d = reg_rdata;
                state_d = S_TX_ACK;
            end
            S_TX_ACK: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
                if (tx_ready) state_d = op_wr_q ? S_IDLE : S_TX_DATA;
            end
            S_TX_DATA: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q;
                if (tx_ready) state_d = S_IDLE;
            end
            S_TX_NAK: begin
                tx_valid = 1'b1;
                tx_data  = NAK_BYTE;
                if (tx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ei_cmd_parser.sv
// Testbench for ei_cmd_parser: table-driven frames with a scoreboard of expected
// register accesses and response bytes, plus hand-written stall, timeout and reset sequences.
module tb_ei_cmd_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err_pulse;
    logic [1:0] err_code;

    ei_cmd_parser #(.NUM_REGS(41), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err_pulse(err_pulse), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Register memory model: read data appears one cycle after reg_re, garbage otherwise.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        reg_rdata <= reg_re ? mem[reg_addr] : 8'hEE;
    end

    typedef struct {
        int           n;
        logic [0:4][7:0] b;
        bit           acc;
        bit           we;
        logic [5:0]   addr;
        logic [7:0]   wdata;
        int           ntx;
        logic [7:0]   tx0;
        logic [7:0]   tx1;
        int           npulse;
        logic [1:0]   code;
    } vec_t;

    vec_t       vecs[11];
    logic [7:0] txq[$];
    logic [15:0] accq[$];
    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: observe DUT outputs on the falling edge, then resume 1 after the rising edge.
    task automatic tick();
        logic [7:0]  et;
        logic [15:0] ea;
        @(negedge clk);
        if (tx_valid && tx_ready) begin
            if (txq.size() == 0) chk("unexpected_tx", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else begin
                et = txq.pop_front();
                chk("tx_byte", {24'h0, tx_data}, {24'h0, et});
            end
        end
        if (reg_we || reg_re) begin
            if (accq.size() == 0) chk("unexpected_access", {16'h0, reg_we, reg_re, 6'h0, reg_addr, 2'b0}, 32'hFFFF_FFFF);
            else begin
                ea = accq.pop_front();
                if (ea[15]) chk("reg_write", {16'h0, reg_we, reg_re, reg_addr, reg_wdata}, {16'h0, ea});
                else        chk("reg_read", {16'h0, reg_we, reg_re, reg_addr, 8'h00}, {16'h0, ea});
            end
        end
        if (err_pulse) pulses++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy && txq.size() == 0 && accq.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(name, {31'h0, done}, 32'h1);
    endtask

    task automatic wait_tx_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(name, {31'h0, seen}, 32'h1);
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        int   p0;
        v  = vecs[idx];
        p0 = pulses;
        if (v.acc) accq.push_back({v.we, !v.we, v.addr, v.we ? v.wdata : 8'h00});
        if (v.ntx > 0) txq.push_back(v.tx0);
        if (v.ntx > 1) txq.push_back(v.tx1);
        for (int i = 0; i < v.n; i++) send_byte(v.b[i]);
        wait_done($sformatf("v%0d_done", idx));
        chk($sformatf("v%0d_pulses", idx), pulses - p0, v.npulse);
        chk($sformatf("v%0d_err_code", idx), {30'h0, err_code}, {30'h0, v.code});
    endtask

    initial begin
        int p0;
        vecs[0]  = '{5, {8'hA5, 8'h57, 8'h03, 8'h10, 8'h44}, 1, 1, 6'h03, 8'h10, 1, 8'h06, 8'h00, 0, 2'b00};
        vecs[1]  = '{4, {8'hA5, 8'h52, 8'h03, 8'h51, 8'h00}, 1, 0, 6'h03, 8'h00, 2, 8'h06, 8'h10, 0, 2'b00};
        vecs[2]  = '{5, {8'hA5, 8'h57, 8'h30, 8'h00, 8'h67}, 0, 0, 6'h00, 8'h00, 1, 8'h15, 8'h00, 1, 2'b10};
        vecs[3]  = '{4, {8'hA5, 8'h52, 8'h03, 8'h00, 8'h00}, 0, 0, 6'h00, 8'h00, 1, 8'h15, 8'h00, 1, 2'b11};
        vecs[4]  = '{3, {8'h00, 8'hA5, 8'h41, 8'h00, 8'h00}, 0, 0, 6'h00, 8'h00, 1, 8'h15, 8'h00, 1, 2'b01};
        vecs[5]  = '{5, {8'hA5, 8'h57, 8'h28, 8'h5A, 8'h25}, 1, 1, 6'h28, 8'h5A, 1, 8'h06, 8'h00, 0, 2'b01};
        vecs[6]  = '{4, {8'hA5, 8'h52, 8'h29, 8'h7B, 8'h00}, 0, 0, 6'h00, 8'h00, 1, 8'h15, 8'h00, 1, 2'b10};
        vecs[7]  = '{4, {8'hA5, 8'h52, 8'h28, 8'h7A, 8'h00}, 1, 0, 6'h28, 8'h00, 2, 8'h06, 8'h5A, 0, 2'b10};
        vecs[8]  = '{5, {8'hA5, 8'h57, 8'h05, 8'hA5, 8'hF7}, 1, 1, 6'h05, 8'hA5, 1, 8'h06, 8'h00, 0, 2'b10};
        vecs[9]  = '{5, {8'hA5, 8'h57, 8'h30, 8'h00, 8'h00}, 0, 0, 6'h00, 8'h00, 1, 8'h15, 8'h00, 1, 2'b11};
        vecs[10] = '{4, {8'hA5, 8'h52, 8'h43, 8'h11, 8'h00}, 0, 0, 6'h00, 8'h00, 1, 8'h15, 8'h00, 1, 2'b10};

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_strobes", {29'h0, reg_we, reg_re, err_pulse}, 32'h0);
        chk("rst_err_code", {30'h0, err_code}, 32'h0);
        chk("rst_reg_bus", {18'h0, reg_addr, reg_wdata}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) apply_vec(i);

        // Inter-byte timeout after A5 57; err_code was 10 going in.
        p0 = pulses;
        send_byte(8'hA5);
        send_byte(8'h57);
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_busy_before", {31'h0, busy}, 32'h1);
        tick();
        chk("tmo_busy_after", {31'h0, busy}, 32'h0);
        chk("tmo_pulses", pulses - p0, 1);
        chk("tmo_err_code", {30'h0, err_code}, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        apply_vec(0);

        // Read with the transmitter stalled: ACK must hold steady until accepted.
        tx_ready = 1'b0;
        accq.push_back({1'b0, 1'b1, 6'h05, 8'h00});
        txq.push_back(8'h06);
        txq.push_back(8'hA5);
        send_byte(8'hA5); send_byte(8'h52); send_byte(8'h05); send_byte(8'h57);
        wait_tx_valid("stall_tx_valid");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_hold%0d", k), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h06});
            tick();
        end
        tx_ready = 1'b1;
        wait_done("stall_done");

        // Reset while TX_DATA is waiting on the transmitter.
        tx_ready = 1'b0;
        accq.push_back({1'b0, 1'b1, 6'h28, 8'h00});
        txq.push_back(8'h06);
        send_byte(8'hA5); send_byte(8'h52); send_byte(8'h28); send_byte(8'h7A);
        wait_tx_valid("rstx_ack_valid");
        chk("rstx_ack_data", {24'h0, tx_data}, 32'h06);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("rstx_data_shown", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h5A});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstx_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rstx_busy", {31'h0, busy}, 32'h0);
        tx_ready = 1'b1;
        send_byte(8'h52);
        chk("rstx_ignore_52", {31'h0, busy}, 32'h0);
        tick();
        tick();
        apply_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
